// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster constants and widths shared by the VGA timing generator
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int FRAME_W = 8;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with registered sync and active decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               wrap_in,
  output logic [COORD_W-1:0] count,
  output logic [COORD_W-1:0] count_next,
  output logic               sync_n,
  output logic               active,
  output logic               wrap_out
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACT_END    = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FRONT);
  localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(ACTIVE + FRONT + SYNC);

  logic at_last;

  assign at_last  = (count == LAST);
  assign wrap_out = enable & wrap_in & at_last;

  always_comb begin
    count_next = count;
    if (enable) begin
      count_next = at_last ? '0 : count + COORD_W'(1);
    end
  end

  // Decode the value being loaded so flags line up with the count they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      sync_n <= 1'b1;
      active <= 1'b1;
    end else begin
      count  <= count_next;
      sync_n <= !((count_next >= SYNC_START) && (count_next < SYNC_END));
      active <= (count_next < ACT_END);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_TIMING_TICK_EN enables line/frame ticks and frame_count
module vga_timing_gen
  import vga_timing_pkg::COORD_W, vga_timing_pkg::FRAME_W;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FRONT  = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BACK   = vga_timing_pkg::H_BACK,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FRONT  = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BACK   = vga_timing_pkg::V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_tick,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_count
);

  logic h_wrap;
  logic h_active;
  logic v_active;
`ifdef VGA_TIMING_TICK_EN
  logic frame_wrap;
`endif

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .clk        (clk),
    .reset      (reset),
    .enable     (1'b1),
    .wrap_in    (1'b1),
    .count      (hpos),
    .count_next (),
    .sync_n     (hsync),
    .active     (h_active),
    .wrap_out   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .clk        (clk),
    .reset      (reset),
    .enable     (h_wrap),
    .wrap_in    (h_wrap),
    .count      (vpos),
    .count_next (),
    .sync_n     (vsync),
    .active     (v_active),
`ifdef VGA_TIMING_TICK_EN
    .wrap_out   (frame_wrap)
`else
    .wrap_out   ()
`endif
  );

  assign display_on = h_active & v_active;

`ifdef VGA_TIMING_TICK_EN
  // Ticks are registered from the wrap decode so they coincide with the (0,*) count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      line_tick  <= h_wrap;
      frame_tick <= frame_wrap;
      if (frame_wrap) begin
        frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end
`else
  assign line_tick   = 1'b0;
  assign frame_tick  = 1'b0;
  assign frame_count = '0;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running 640x480@60 Hz VGA raster timing generator at the head of the TinyTapeout pixel pipeline. Produces pixel coordinates and the hsync/vsync/display_on triple consumed by the pixel renderer and the output pin mapper. Also produces single-cycle frame and line tick strobes that pace the gravity physics engine. All outputs are registered and mutually aligned to the same cycle.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal); single clock domain
- reset  in  1  asynchronous, active-high reset
- hpos  out  10  horizontal pixel counter, 0..H_TOTAL-1
- vpos  out  10  vertical line counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- display_on  out  1  high inside the visible 640x480 window
- line_tick  out  1  one-cycle strobe when hpos wraps to 0
- frame_tick  out  1  one-cycle strobe when (hpos,vpos) wraps to (0,0)
- frame_count  out  8  frames completed since reset, modulo 256

## Operation
- H_TOTAL = sum of H_* (800). V_TOTAL = sum of V_* (525).
- hpos increments every clock. At H_TOTAL-1 it wraps to 0 and vpos advances. vpos wraps from V_TOTAL-1 to 0.
- hsync = 0 iff H_ACTIVE+H_FRONT <= hpos < H_ACTIVE+H_FRONT+H_SYNC (656..751).
- vsync = 0 iff V_ACTIVE+V_FRONT <= vpos < V_ACTIVE+V_FRONT+V_SYNC (490..491).
- display_on = (hpos < H_ACTIVE) && (vpos < V_ACTIVE).
- hsync, vsync and display_on are decoded from the next-state counter values and registered. They therefore describe the same (hpos,vpos) presented in the same cycle. No combinational decode reaches an output.
- line_tick = 1 in the cycle hpos == 0, except the cycle immediately after reset.
- frame_tick = 1 in the cycle (hpos,vpos) == (0,0), except the cycle immediately after reset.
- frame_count increments in the cycle frame_tick rises and wraps 255 -> 0.
- Counter arithmetic is unsigned, 10 bits. Compare against wrap constants with ==, not overflow.

## Timing
- Reset values: hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, line_tick=0, frame_tick=0, frame_count=0.
- Reset asserted mid-frame: all outputs go to reset values asynchronously. Counting resumes from (0,0) on the first clk edge after deassertion, giving (1,0) after that edge.
- Line period is exactly 800 clocks. Frame period is exactly 420000 clocks.
- First line_tick is 800 cycles after reset deassertion. First frame_tick is 420000 cycles after it.
- At each frame wrap, frame_tick and line_tick assert in the same cycle.
- Latency from counter state to sync/display outputs is 0 cycles (aligned).

## Configuration
- Macro: VGA_TIMING_TICK_EN.
- Defined: line_tick, frame_tick and frame_count operate as specified.
- Undefined: line_tick and frame_tick are tied to 0, and frame_count is tied to 0. The frame_count register is not synthesized. Consumers must then derive ticks from hpos/vpos themselves.

## Structure
- Package vga_timing_pkg holds:
  - 640x480@60 localparams (H_/V_ ACTIVE, FRONT, SYNC, BACK, TOTAL)
  - the coordinate width (10)
  - the frame counter width (8)
- Sub-module vga_axis_counter is parameterized by ACTIVE/FRONT/SYNC/BACK.
  - Inputs: enable and wrap-in.
  - Outputs: count, next-count, registered sync_n, registered active, wrap-out.
  - It is instantiated twice. The horizontal instance has enable tied to 1. The vertical instance is enabled by the horizontal wrap.
- The top level combines the active flags and owns the tick and frame_count registers.

## Test plan
- Reset release: hold reset 5 cycles, release.
  - During reset: hpos=0, vpos=0, hsync=1, vsync=1, display_on=1, frame_count=0.
  - 1 cycle after release: hpos=1.
- Horizontal sweep over one line:
  - display_on falls at hpos=640.
  - hsync is low exactly at hpos 656..751 (96 cycles).
  - hpos wraps 799 -> 0 with line_tick=1 and vpos 0 -> 1.
- Vertical sweep over one frame:
  - display_on stays 0 for vpos 480..524.
  - vsync is low for exactly 1600 cycles, at vpos 490..491.
  - vpos wraps 524 -> 0.
- Frame strobe: run 3 frames.
  - frame_tick is high exactly once per 420000 cycles, coincident with line_tick.
  - frame_count reads 1, 2, 3.
- Mid-frame reset: assert reset at hpos=300, vpos=200 for 2 cycles.
  - All outputs return to reset values immediately.
  - Next frame_tick occurs 420000 cycles after deassertion.
- Macro off (VGA_TIMING_TICK_EN undefined):
  - line_tick, frame_tick and frame_count remain 0 across 2 frames.
  - sync/display waveforms are identical to the macro-on run.
